avmm_burst_mem_slave: RTL and testbench

//   Avalon-MM slave (responder) backed by a word-addressed on-chip memory array.
//   It answers the master side of the team's avalon_if, with burst reads/writes, fixed read latency,

---
 rtl/avmm_burst_mem_slave.sv | 126 ++++++++++++
 tb/tb_avmm_burst_mem_slave.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avmm_burst_mem_slave.sv
// Avalon-MM burst slave backed by a word-addressed on-chip array.
// Fixed read latency, waitrequest while a read burst is in flight, byte-enabled writes.
module avmm_burst_mem_slave #(
  parameter int ADDR_WIDTH      = 11,
  parameter int DATA_WIDTH      = 64,
  parameter int BURST_CNT_WIDTH = 4,
  parameter int READ_LATENCY    = 2
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [ADDR_WIDTH-1:0]               address,
  input  logic                                read,
  input  logic                                write,
  input  logic [BURST_CNT_WIDTH-1:0]          burstcount,
  input  logic [DATA_WIDTH-1:0]               writedata,
  input  logic [((DATA_WIDTH+7)/8)-1:0]       byteenable,
  output logic                                waitrequest,
  output logic [DATA_WIDTH-1:0]               readdata,
  output logic                                readdatavalid,
  output logic                                protocol_err
);

  // state    | meaning
  // IDLE     | ready for a new read or write burst
  // WR_BURST | accepting the remaining beats of a write burst
  // RD_WAIT  | counting out the read latency before the first beat
  // RD_BURST | issuing one read beat per cycle, then one closing cycle
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WR_BURST = 2'd1;
  localparam logic [1:0] RD_WAIT  = 2'd2;
  localparam logic [1:0] RD_BURST = 2'd3;

  localparam int LAT_LOAD = (READ_LATENCY >= 2) ? READ_LATENCY - 2 : 0;
  localparam int LAT_W    = (LAT_LOAD > 0) ? $clog2(LAT_LOAD + 1) : 1;

  logic [1:0]                 state;
  logic [ADDR_WIDTH-1:0]      burst_addr;
  logic [BURST_CNT_WIDTH-1:0] remaining;
  logic [LAT_W-1:0]           lat_cnt;
  logic [BURST_CNT_WIDTH-1:0] bc_eff;
  logic                       mem_we;
  logic [ADDR_WIDTH-1:0]      mem_waddr;
  logic [DATA_WIDTH-1:0]      be_mask;
  logic [DATA_WIDTH-1:0]      mem [2**ADDR_WIDTH];

  assign bc_eff      = (burstcount == '0) ? BURST_CNT_WIDTH'(1) : burstcount;
  assign waitrequest = reset | (state == RD_WAIT) | (state == RD_BURST);

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = address;
    if (!reset && write) begin
      if (state == IDLE) begin
        mem_we = 1'b1;
      end else if (state == WR_BURST) begin
        mem_we    = 1'b1;
        mem_waddr = burst_addr;
      end
    end
  end

  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_mask
    assign be_mask[i] = byteenable[i/8];
  end

  // Memory has no reset: contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= (mem[mem_waddr] & ~be_mask) | (writedata & be_mask);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      readdata      <= '0;
      readdatavalid <= 1'b0;
      protocol_err  <= 1'b0;
      burst_addr    <= '0;
      remaining     <= '0;
      lat_cnt       <= '0;
    end else begin
      readdatavalid <= 1'b0;
      case (state)
        IDLE: begin
          if (write) begin
            if (read) protocol_err <= 1'b1;
            burst_addr <= address + 1'b1;
            remaining  <= bc_eff - 1'b1;
            if (bc_eff != BURST_CNT_WIDTH'(1)) state <= WR_BURST;
          end else if (read) begin
            burst_addr <= address;
            remaining  <= bc_eff;
            lat_cnt    <= LAT_W'(LAT_LOAD);
            state      <= (READ_LATENCY <= 1) ? RD_BURST : RD_WAIT;
          end
        end
        WR_BURST: begin
          if (read) protocol_err <= 1'b1;
          if (write) begin
            burst_addr <= burst_addr + 1'b1;
            remaining  <= remaining - 1'b1;
            if (remaining == BURST_CNT_WIDTH'(1)) state <= IDLE;
          end
        end
        RD_WAIT: begin
          if (lat_cnt == '0) state <= RD_BURST;
          else               lat_cnt <= lat_cnt - 1'b1;
        end
        RD_BURST: begin
          // Extra cycle after the last beat keeps waitrequest high while it is presented.
          if (remaining != '0) begin
            readdata      <= mem[burst_addr];
            readdatavalid <= 1'b1;
            burst_addr    <= burst_addr + 1'b1;
            remaining     <= remaining - 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_avmm_burst_mem_slave.sv
// Self-checking bench for avmm_burst_mem_slave: cycle-schedule reference model plus directed literal checks.
module tb_avmm_burst_mem_slave;
  localparam int AW = 11;
  localparam int DW = 64;
  localparam int BW = 4;
  localparam int L  = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] address = '0;
  logic          read = 1'b0;
  logic          write = 1'b0;
  logic [BW-1:0] burstcount = '0;
  logic [DW-1:0] writedata = '0;
  logic [7:0]    byteenable = '0;
  logic          waitrequest;
  logic [DW-1:0] readdata;
  logic          readdatavalid;
  logic          protocol_err;

  always #5 clk = ~clk;

  avmm_burst_mem_slave #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_CNT_WIDTH(BW), .READ_LATENCY(L)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
    .burstcount(burstcount), .writedata(writedata), .byteenable(byteenable),
    .waitrequest(waitrequest), .readdata(readdata), .readdatavalid(readdatavalid),
    .protocol_err(protocol_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: memory image, read-beat schedule keyed by cycle, busy window end.
  int            cyc = 0;
  int            busy_end = 0;
  int            wr_rem = 0;
  logic [AW-1:0] wr_addr = '0;
  bit            m_err = 0;
  bit            cur_v = 0;
  bit            m_live = 0;
  logic [63:0]   last_d = '0;
  logic [63:0]   mmem [2**AW];
  bit            exp_v [int];
  logic [63:0]   exp_d [int];

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d, input logic [7:0] be);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) begin : model
    int c, n;
    bit w_prev;
    logic [AW-1:0] a;
    w_prev = (cyc < busy_end);
    c = cyc + 1;
    if (reset) begin
      exp_v.delete();
      exp_d.delete();
      busy_end = 0;
      wr_rem   = 0;
      m_err    = 0;
      last_d   = '0;
      cur_v    = 0;
      m_live   = 1;
    end else begin
      n = (burstcount == 0) ? 1 : int'(burstcount);
      if (!w_prev && (read || write)) begin
        if (write) begin
          if (wr_rem > 0) begin
            mmem[wr_addr] = merge(mmem[wr_addr], writedata, byteenable);
            wr_addr = wr_addr + 1'b1;
            wr_rem--;
          end else begin
            mmem[address] = merge(mmem[address], writedata, byteenable);
            wr_addr = address + 1'b1;
            wr_rem  = n - 1;
          end
          if (read) m_err = 1;
        end else if (wr_rem > 0) begin
          m_err = 1;
        end else begin
          for (int i = 0; i < n; i++) begin
            a = address + AW'(i);
            exp_v[c + L + i] = 1;
            exp_d[c + L + i] = mmem[a];
          end
          busy_end = c + L + n;
        end
      end
      cur_v = exp_v.exists(c);
      if (cur_v) begin
        last_d = exp_d[c];
        exp_v.delete(c);
        exp_d.delete(c);
      end
    end
    cyc = c;
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("waitrequest", waitrequest, (reset || cyc < busy_end));
      check("readdatavalid", readdatavalid, cur_v);
      check("readdata", readdata, last_d);
      check("protocol_err", protocol_err, m_err);
    end
  end

  // Driver helpers: all called at posedge+1 and return at posedge+1.
  task automatic do_req(input bit rd, input bit wr, input logic [AW-1:0] a, input logic [BW-1:0] bc,
                        input logic [63:0] wd, input logic [7:0] be, output bit ok);
    logic w;
    read = rd; write = wr; address = a; burstcount = bc; writedata = wd; byteenable = be;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      w = waitrequest;
      @(posedge clk);
      #1;
      if (!w) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL req_timeout: got no acceptance expected acceptance within 200 cycles");
    end
    read = 0;
    write = 0;
  endtask

  logic [63:0] bd [16];
  logic [7:0]  bbe [16];
  bit          bbub [16];
  bit          brd [16];

  task automatic clear_burst();
    for (int i = 0; i < 16; i++) begin
      bd[i] = '0; bbe[i] = 8'hFF; bbub[i] = 0; brd[i] = 0;
    end
  endtask

  task automatic wr_burst(input logic [AW-1:0] a, input int n);
    bit ok;
    int ne;
    ne = (n == 0) ? 1 : n;
    do_req(brd[0], 1, a, BW'(n), bd[0], bbe[0], ok);
    for (int i = 1; i < ne; i++) begin
      if (bbub[i]) begin
        @(posedge clk);
        #1;
      end
      do_req(brd[i], 1, a, BW'(n), bd[i], bbe[i], ok);
    end
  endtask

  logic [63:0] rb_d [16];
  int          rb_c [16];
  int          nb;

  task automatic collect(input int n);
    nb = 0;
    for (int i = 0; i < n + 40 && nb < n; i++) begin
      @(negedge clk);
      if (readdatavalid) begin
        rb_d[nb] = readdata;
        rb_c[nb] = cyc;
        nb++;
      end
    end
    check("beats_seen", 64'(nb), 64'(n));
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse(input int k);
    reset = 1;
    repeat (k) @(posedge clk);
    #1;
    reset = 0;
  endtask

  initial begin
    bit ok;
    int acc, acc2, cnt, beats;
    logic [63:0] t6d [4];

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_wait", waitrequest, 1);
    check("rst_rdv", readdatavalid, 0);
    check("rst_readdata", readdata, 0);
    check("rst_err", protocol_err, 0);
    @(posedge clk);
    #1;
    reset = 0;
    @(negedge clk);
    check("wait_after_reset", waitrequest, 0);
    @(posedge clk);
    #1;

    // Fill the whole array so every later read has a known reference value.
    clear_burst();
    for (int s = 0; s < 2**AW; s += 15) begin
      for (int i = 0; i < 16; i++) bd[i] = {$urandom, $urandom};
      wr_burst(AW'(s), 15);
    end

    // T1
    clear_burst();
    bd[0] = 64'h1122334455667788;
    wr_burst(11'h010, 1);
    do_req(1, 0, 11'h010, 4'd1, '0, '0, ok);
    acc = cyc;
    collect(1);
    check("t1_latency", 64'(rb_c[0] - acc), 64'(L));
    check("t1_data", rb_d[0], 64'h1122334455667788);

    // T2
    clear_burst();
    for (int i = 0; i < 4; i++) bd[i] = 64'(i + 1);
    bbub[1] = 1;
    wr_burst(11'h7FE, 4);
    do_req(1, 0, 11'h7FE, 4'd4, '0, '0, ok);
    collect(4);
    for (int i = 0; i < 4; i++) check("t2_beat", rb_d[i], 64'(i + 1));
    check("t2_consecutive", 64'(rb_c[3] - rb_c[0]), 64'd3);
    do_req(1, 0, 11'h000, 4'd0, '0, '0, ok);
    collect(1);
    check("t2_wrap_addr0", rb_d[0], 64'd3);

    // T3
    clear_burst();
    bd[0] = 64'hFFFFFFFFFFFFFFFF;
    wr_burst(11'h020, 1);
    bd[0] = 64'h0;
    bbe[0] = 8'h0F;
    wr_burst(11'h020, 1);
    do_req(1, 0, 11'h020, 4'd1, '0, '0, ok);
    collect(1);
    check("t3_byteenable", rb_d[0], 64'hFFFFFFFF00000000);

    // T4: second read held by the master across the whole first burst
    do_req(1, 0, 11'h030, 4'd3, '0, '0, ok);
    acc = cyc;
    do_req(1, 0, 11'h040, 4'd1, '0, '0, ok);
    acc2 = cyc;
    check("t4_second_accept", 64'(acc2 - acc), 64'(L + 3 + 1));
    check("t4_err", protocol_err, 0);
    collect(1);

    // T5
    do_req(1, 1, 11'h050, 4'd1, 64'hCAFEF00D12345678, 8'hFF, ok);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (readdatavalid) cnt++;
    end
    @(posedge clk);
    #1;
    check("t5_no_rdv", 64'(cnt), 0);
    check("t5_err_set", protocol_err, 1);
    do_req(1, 0, 11'h050, 4'd1, '0, '0, ok);
    collect(1);
    check("t5_write_done", rb_d[0], 64'hCAFEF00D12345678);
    check("t5_err_sticky", protocol_err, 1);
    rst_pulse(1);
    @(negedge clk);
    check("t5_err_cleared", protocol_err, 0);
    @(posedge clk);
    #1;

    // T6
    clear_burst();
    for (int i = 0; i < 4; i++) begin
      t6d[i] = 64'hA0 + 64'(i);
      bd[i]  = t6d[i];
    end
    wr_burst(11'h100, 4);
    do_req(1, 0, 11'h100, 4'd4, '0, '0, ok);
    beats = 0;
    for (int i = 0; i < 20 && beats < 2; i++) begin
      @(posedge clk);
      #1;
      if (readdatavalid) beats++;
    end
    check("t6_reached_beat2", 64'(beats), 2);
    reset = 1;
    @(negedge clk);
    check("t6_wait_in_reset", waitrequest, 1);
    @(posedge clk);
    #1;
    reset = 0;
    @(negedge clk);
    check("t6_rdv_after_reset", readdatavalid, 0);
    check("t6_wait_after_reset", waitrequest, 0);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (readdatavalid) cnt++;
    end
    @(posedge clk);
    #1;
    check("t6_no_late_beats", 64'(cnt), 0);
    do_req(1, 0, 11'h100, 4'd4, '0, '0, ok);
    collect(4);
    for (int i = 0; i < 4; i++) check("t6_mem_intact", rb_d[i], t6d[i]);

    // Randomized traffic, checked cycle by cycle against the model.
    for (int op = 0; op < 300; op++) begin
      int k;
      k = $urandom_range(0, 9);
      if (k <= 3) begin
        for (int i = 0; i < 16; i++) begin
          bd[i]   = {$urandom, $urandom};
          bbe[i]  = 8'($urandom);
          bbub[i] = ($urandom_range(0, 3) == 0);
          brd[i]  = (i > 0) && ($urandom_range(0, 15) == 0);
        end
        brd[0] = 0;
        wr_burst(AW'($urandom), int'($urandom_range(0, 15)));
      end else if (k <= 7) begin
        do_req(1, 0, AW'($urandom), BW'($urandom_range(0, 15)), '0, '0, ok);
      end else if (k == 8) begin
        do_req(1, 1, AW'($urandom), 4'd1, {$urandom, $urandom}, 8'($urandom), ok);
      end else begin
        do_req(1, 0, AW'($urandom), BW'($urandom_range(1, 15)), '0, '0, ok);
        repeat ($urandom_range(0, 8)) @(posedge clk);
        #1;
        rst_pulse(int'($urandom_range(1, 2)));
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (30) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
